automatic_washing_machine: RTL and testbench
============================================

# automatic_washing_machine

Controller FSM for an automatic washing machine: sequences door check, water fill, detergent dosing, wash, drain, rinse and spin from plant sensor and timer inputs, and drives motor, valves, door lock and a completion flag. It sits between the sensor/timer front end and the actuator drivers. Timers are external; this block only reacts to their timeout strobes.

## Interface
- No parameters.
- Clock  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low (0 = reset)
- Start  input  1  user start request (level)
- Door_Close  input  1  door closed sensor (level)
- Filled  input  1  water level reached
- Drained  input  1  drum empty
- Detergent_Added  input  1  detergent dosing complete
- Cycle_Timeout  input  1  wash/rinse timer expired
- Spin_Timeout  input  1  spin timer expired
- Motor_on  output  1  drum motor enable
- Fill_valve_on  output  1  inlet valve enable
- Drained_valve_on  output  1  drain valve enable
- Door_Lock  output  1  door lock actuator
- Done  output  1  wash program complete

## Operation
- Moore FSM; outputs decoded from current state only.
- Internal 1-bit rinse flag: 0 = wash pass, 1 = rinse pass.
- States, outputs (Motor/Fill/Drain/Lock/Done), transitions:
  - CHECK_DOOR (0/0/0/0/0): Start & Door_Close -> FILL_WATER; clears rinse flag.
  - FILL_WATER (0/1/0/1/0): Filled & rinse=0 -> ADD_DETERGENT; Filled & rinse=1 -> CYCLE.
  - ADD_DETERGENT (0/0/0/1/0): Detergent_Added -> CYCLE.
  - CYCLE (1/0/0/1/0): Cycle_Timeout -> DRAIN_WATER.
  - DRAIN_WATER (0/0/1/1/0): Drained & rinse=0 -> FILL_WATER, set rinse=1; Drained & rinse=1 -> SPIN.
  - SPIN (1/0/1/1/0): Spin_Timeout -> DONE.
  - DONE (0/0/0/0/1): Start=0 -> CHECK_DOOR; else hold (no auto-restart while Start held).
- Any state: advancing condition false -> stay.
- Door_Close checked only in CHECK_DOOR; door locked thereafter, deassertion mid-program ignored.
- Inputs are levels; stale-high inputs advance the next matching state immediately (e.g. Filled still high on rinse fill).
- Unused state encodings -> CHECK_DOOR next cycle.

## Timing
- Reset low: state = CHECK_DOOR, rinse = 0, all outputs 0, immediately (async), held while low.
- Reset release: first transition evaluated at first rising Clock after Reset high.
- One transition per rising edge; input sampled at edge N -> new state and outputs valid after edge N (1-cycle latency, no combinational input-to-output path).
- Full program with all conditions held true: CHECK_DOOR -> FILL -> ADD_DET -> CYCLE -> DRAIN -> FILL -> CYCLE -> DRAIN -> SPIN -> DONE = 9 edges from first qualifying edge to Done=1.
- Simultaneous inputs: only the current state's condition matters; others ignored that cycle.
- Reset asserted mid-program: abort to CHECK_DOOR, all actuators off, lock released, rinse cleared.

## Test plan
- Reset low mid-SPIN -> Motor_on, Drained_valve_on, Door_Lock drop to 0 without clock edge; state CHECK_DOOR after release.
- Start=1, Door_Close=0 for 10 cycles -> stays CHECK_DOOR, all outputs 0; then Door_Close=1 -> next edge Fill_valve_on=1, Door_Lock=1.
- Staggered bench sequence (Start/Door_Close, then Filled, Detergent_Added, Cycle_Timeout, Drained, Spin_Timeout each raised 1 cycle apart, held) -> states visit FILL, ADD_DET, CYCLE, DRAIN, FILL(rinse), CYCLE, DRAIN, SPIN, DONE in order; Done=1, Door_Lock=0 at end.
- Rinse pass skips detergent: second FILL_WATER with Filled=1 -> CYCLE next edge, ADD_DETERGENT never entered.
- DONE with Start held 1 -> Done stays 1 indefinitely; Start=0 -> next edge CHECK_DOOR, Done=0.
- Door_Close=0 during CYCLE -> Motor_on and Door_Lock remain 1, program proceeds on Cycle_Timeout.

Source files
------------

// File: rtl/automatic_washing_machine.sv
// Washing machine program sequencer: door check, fill, dose, wash, drain, rinse, spin.
// Moore outputs are registered alongside the state so no input reaches an actuator combinationally.
module automatic_washing_machine (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Door_Close,
  input  logic Filled,
  input  logic Drained,
  input  logic Detergent_Added,
  input  logic Cycle_Timeout,
  input  logic Spin_Timeout,
  output logic Motor_on,
  output logic Fill_valve_on,
  output logic Drained_valve_on,
  output logic Door_Lock,
  output logic Done
);

  localparam int unsigned ACT_W = 5;

  typedef enum logic [2:0] {
    CHECK_DOOR    = 3'd0,
    FILL_WATER    = 3'd1,
    ADD_DETERGENT = 3'd2,
    CYCLE         = 3'd3,
    DRAIN_WATER   = 3'd4,
    SPIN          = 3'd5,
    DONE          = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic               rinse, rinse_nxt;
  logic [ACT_W-1:0]   act_nxt;

  // State, rinse flag and decoded actuator registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= CHECK_DOOR;
      rinse            <= 1'b0;
      Motor_on         <= 1'b0;
      Fill_valve_on    <= 1'b0;
      Drained_valve_on <= 1'b0;
      Door_Lock        <= 1'b0;
      Done             <= 1'b0;
    end else begin
      state <= state_nxt;
      rinse <= rinse_nxt;
      {Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done} <= act_nxt;
    end
  end

  // Next-state logic; only the current state's advance condition is looked at
  always_comb begin
    state_nxt = state;
    rinse_nxt = rinse;
    case (state)
      CHECK_DOOR: begin
        if (Start && Door_Close) begin
          state_nxt = FILL_WATER;
          rinse_nxt = 1'b0;
        end
      end
      FILL_WATER: begin
        if (Filled) state_nxt = rinse ? CYCLE : ADD_DETERGENT;
      end
      ADD_DETERGENT: begin
        if (Detergent_Added) state_nxt = CYCLE;
      end
      CYCLE: begin
        if (Cycle_Timeout) state_nxt = DRAIN_WATER;
      end
      DRAIN_WATER: begin
        if (Drained) begin
          if (rinse) begin
            state_nxt = SPIN;
          end else begin
            state_nxt = FILL_WATER;
            rinse_nxt = 1'b1;
          end
        end
      end
      SPIN: begin
        if (Spin_Timeout) state_nxt = DONE;
      end
      DONE: begin
        if (!Start) state_nxt = CHECK_DOOR;
      end
      default: state_nxt = CHECK_DOOR;
    endcase
  end

  // Actuator decode of the upcoming state: {motor, fill, drain, lock, done}
  always_comb begin
    act_nxt = ACT_W'(0);
    case (state_nxt)
      FILL_WATER:    act_nxt = 5'b01010;
      ADD_DETERGENT: act_nxt = 5'b00010;
      CYCLE:         act_nxt = 5'b10010;
      DRAIN_WATER:   act_nxt = 5'b00110;
      SPIN:          act_nxt = 5'b10110;
      DONE:          act_nxt = 5'b00001;
      default:       act_nxt = ACT_W'(0);
    endcase
  end

endmodule

// File: tb/tb_automatic_washing_machine.sv
// Directed bench for automatic_washing_machine; states are identified by their actuator pattern.
module tb_automatic_washing_machine;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, door_close = 1'b0, filled = 1'b0, drained = 1'b0;
  logic det_added = 1'b0, cyc_to = 1'b0, spin_to = 1'b0;
  logic motor_on, fill_on, drain_on, door_lock, done;
  logic [4:0] act;

  int n_checks = 0;
  int n_errors = 0;

  // {motor, fill, drain, lock, done} for each state
  localparam logic [4:0] O_CHK  = 5'b00000;
  localparam logic [4:0] O_FILL = 5'b01010;
  localparam logic [4:0] O_ADD  = 5'b00010;
  localparam logic [4:0] O_CYC  = 5'b10010;
  localparam logic [4:0] O_DRN  = 5'b00110;
  localparam logic [4:0] O_SPIN = 5'b10110;
  localparam logic [4:0] O_DONE = 5'b00001;

  automatic_washing_machine dut (
    .Clock           (clk),
    .Reset           (rst_n),
    .Start           (start),
    .Door_Close      (door_close),
    .Filled          (filled),
    .Drained         (drained),
    .Detergent_Added (det_added),
    .Cycle_Timeout   (cyc_to),
    .Spin_Timeout    (spin_to),
    .Motor_on        (motor_on),
    .Fill_valve_on   (fill_on),
    .Drained_valve_on(drain_on),
    .Door_Lock       (door_lock),
    .Done            (done)
  );

  assign act = {motor_on, fill_on, drain_on, door_lock, done};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] seq [9];

  initial begin
    seq = '{O_FILL, O_ADD, O_CYC, O_DRN, O_FILL, O_CYC, O_DRN, O_SPIN, O_DONE};

    // Async reset at power-up
    #1 rst_n = 1'b0;
    #2 check("reset_async", act, O_CHK);
    tick();
    check("reset_held", act, O_CHK);
    tick();
    rst_n = 1'b1;

    // Start without closed door never leaves CHECK_DOOR
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("door_open_%0d", i), act, O_CHK);
    end
    door_close = 1'b1;
    tick(); check("door_closed_fill", act, O_FILL);

    // Manual walk with stalls; door opened mid-program is ignored
    door_close = 1'b0;
    tick(); check("fill_wait", act, O_FILL);
    filled = 1'b1;
    tick(); check("add_det", act, O_ADD);
    tick(); check("add_det_wait", act, O_ADD);
    det_added = 1'b1;
    tick(); check("cycle", act, O_CYC);
    tick(); check("cycle_door_open", act, O_CYC);
    cyc_to = 1'b1;
    tick(); check("drain", act, O_DRN);
    tick(); check("drain_wait", act, O_DRN);
    drained = 1'b1;
    tick(); check("rinse_fill", act, O_FILL);
    tick(); check("rinse_skip_det", act, O_CYC);
    tick(); check("rinse_drain", act, O_DRN);
    tick(); check("spin", act, O_SPIN);
    tick(); check("spin_wait", act, O_SPIN);
    spin_to = 1'b1;
    tick(); check("done", act, O_DONE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("done_hold_%0d", i), act, O_DONE);
    end
    start = 1'b0;
    tick(); check("done_release", act, O_CHK);

    // All conditions held true: nine edges to Done
    start = 1'b1; door_close = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("full_prog_%0d", i), act, seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_hold_%0d", i), act, O_DONE);
    end

    // Abort mid-SPIN by reset; rinse flag must be cleared
    start = 1'b0;
    tick(); check("restart_chk", act, O_CHK);
    start = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("pre_abort_spin", act, O_SPIN);
    #2 rst_n = 1'b0;
    #1 check("abort_async", act, O_CHK);
    tick(); check("abort_held", act, O_CHK);
    start = 1'b0;
    rst_n = 1'b1;
    tick(); check("post_abort_chk", act, O_CHK);
    start = 1'b1;
    tick(); check("post_abort_fill", act, O_FILL);
    tick(); check("post_abort_wash_pass", act, O_ADD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
